// File: rtl/level_meter_pkg.sv
// Shared widths, hold limit and FSM state type for the level meter.
package level_meter_pkg;
    localparam int unsigned SMP_W    = 8;
    localparam int unsigned PEAK_W   = 7;
    localparam int unsigned LVL_W    = 4;
    localparam int unsigned HOLD_W   = 3;
    localparam int unsigned HOLD_MAX = 7;

    typedef enum logic {
        IDLE,
        DECAY
    } state_t;
endpackage

// File: rtl/level_meter_if.sv
// Audio sample bus feeding the level meter (valid, channel, signed data).
interface level_meter_if;
    import level_meter_pkg::*;

    logic             smp_valid;
    logic [1:0]       smp_ch;
    logic [SMP_W-1:0] smp_data;

    modport master (output smp_valid, smp_ch, smp_data);
    modport slave  (input  smp_valid, smp_ch, smp_data);
endinterface

// File: rtl/level_meter_abs_sat.sv
// abs_sat: combinational |x| of a signed sample, saturated to PEAK_W bits.
module abs_sat
    import level_meter_pkg::*;
(
    input  logic [SMP_W-1:0]  data,
    output logic [PEAK_W-1:0] mag
);
    logic [SMP_W-1:0] neg;

    assign neg = -data;

    always_comb begin
        mag = data[PEAK_W-1:0];
        if (data[SMP_W-1]) begin
            // only the most negative code overflows after negation
            mag = neg[SMP_W-1] ? '1 : neg[PEAK_W-1:0];
        end
    end
endmodule

// File: rtl/level_meter.sv
// Four-channel peak level meter with line-paced decay for a VGA display.
// Optional per-channel peak hold is enabled with LEVEL_METER_HOLD_EN.
module level_meter
    import level_meter_pkg::*;
#(
    parameter int unsigned DECAY_LINES = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ena,
    input  logic             hline,
    level_meter_if.slave     smp,
    output logic [LVL_W-1:0] s1,
    output logic [LVL_W-1:0] s2,
    output logic [LVL_W-1:0] s3,
    output logic [LVL_W-1:0] s4,
    output logic             busy
);
    localparam int unsigned      CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_LINES - 1);

    logic [PEAK_W-1:0] mag;
    logic [CNT_W-1:0]  cnt;
    logic              line;
    logic              tick;
    state_t            state, state_nxt;
    logic [1:0]        idx, idx_nxt;
    logic [PEAK_W-1:0] peak     [4];
    logic [PEAK_W-1:0] peak_nxt [4];
`ifdef LEVEL_METER_HOLD_EN
    logic [HOLD_W-1:0] hold     [4];
    logic [HOLD_W-1:0] hold_nxt [4];
`endif

    abs_sat u_abs_sat (
        .data (smp.smp_data),
        .mag  (mag)
    );

    assign line = ena & hline;
    assign tick = line & (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state_nxt = DECAY;
                        idx_nxt   = '0;
                    end
                end
                DECAY: begin
                    idx_nxt = idx + 2'd1;
                    if (idx == 2'd3) state_nxt = IDLE;
                end
            endcase
        end
    end

    // Decay is applied first so a same-cycle sample competes with the decayed value.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            peak_nxt[i] = peak[i];
`ifdef LEVEL_METER_HOLD_EN
            hold_nxt[i] = hold[i];
`endif
            if (ena) begin
                if (state == DECAY && idx == 2'(i)) begin
`ifdef LEVEL_METER_HOLD_EN
                    if (hold[i] != '0)      hold_nxt[i] = hold[i] - 1'b1;
                    else if (peak[i] != '0) peak_nxt[i] = peak[i] - 1'b1;
`else
                    if (peak[i] != '0) peak_nxt[i] = peak[i] - 1'b1;
`endif
                end
                if (smp.smp_valid && smp.smp_ch == 2'(i)) begin
                    if (mag > peak_nxt[i]) peak_nxt[i] = mag;
`ifdef LEVEL_METER_HOLD_EN
                    if (mag > peak[i]) hold_nxt[i] = HOLD_W'(HOLD_MAX);
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            s4    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                peak[i] <= '0;
`ifdef LEVEL_METER_HOLD_EN
                hold[i] <= '0;
`endif
            end
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            busy  <= (state_nxt == DECAY);
            for (int unsigned i = 0; i < 4; i++) begin
                peak[i] <= peak_nxt[i];
`ifdef LEVEL_METER_HOLD_EN
                hold[i] <= hold_nxt[i];
`endif
            end
            if (line) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                s1  <= peak[0][PEAK_W-1 -: LVL_W];
                s2  <= peak[1][PEAK_W-1 -: LVL_W];
                s3  <= peak[2][PEAK_W-1 -: LVL_W];
                s4  <= peak[3][PEAK_W-1 -: LVL_W];
            end
        end
    end
endmodule

// File: doc/level_meter.md
LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 Parameter DECAY_LINES, default 64: the number of accepted hline pulses per decay tick; legal range 1..1023.
REQ-002 clock  input  1  the single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 ena  input  1  pixel-rate enable; state advances only when high.
REQ-005 hline  input  1  end-of-visible-line strobe from the VGA stage; counted only when ena is high.
REQ-006 smp_valid  input  1  qualifies smp_ch and smp_data; accepted when smp_valid and ena are both high.
REQ-007 smp_ch  input  2  target channel of the sample, 0..3.
REQ-008 smp_data  input  8  signed two's-complement audio sample.
REQ-009 s1, s2, s3, s4  output  4 each  per-channel display levels for the VGA stage; registered.
REQ-010 busy  output  1  high while the FSM is in DECAY; registered.

Function
REQ-011 The magnitude of a sample shall be |smp_data| saturated to 7 bits, so -128 maps to 127 and 0 maps to 0.
REQ-012 Each channel shall hold a 7-bit peak register.
REQ-013 On an accepted sample, peak[smp_ch] shall update on the next edge to max(peak, magnitude); latency is 1 cycle.
REQ-014 The decay counter shall increment on each hline&ena pulse and wrap from DECAY_LINES-1 to 0.
REQ-015 The wrap shall raise a one-cycle decay tick; DECAY_LINES=1 gives one tick per hline.
REQ-016 The FSM shall have two states, IDLE and DECAY.
REQ-017 In IDLE, a decay tick shall move the FSM to DECAY with the channel index at 0.
REQ-018 In DECAY, one channel shall be processed per enabled cycle, in index order 0,1,2,3; the FSM returns to IDLE after channel 3, so DECAY lasts exactly 4 enabled cycles.
REQ-019 Processing a channel shall set peak = peak-1 if peak>0, and leave it at 0 otherwise; the peak never underflows.
REQ-020 A sample for the channel being processed in the same cycle shall produce peak = max(magnitude, decayed peak).
REQ-021 A sample for any other channel shall follow REQ-013 unchanged.
REQ-022 A decay tick arriving while the FSM is in DECAY shall be dropped; the counter keeps counting.
REQ-023 On hline&ena, s1..s4 shall load peak[0..3][6:3], taken from the peak values before that edge's update.
REQ-024 s1..s4 shall change at no other time, so each displayed line is glitch-free.
REQ-025 When ena is low, all registers shall hold their values and the inputs shall be ignored.

Reset
REQ-026 While reset_n is low, all peaks, s1..s4, the decay counter and the channel index shall be 0, the FSM shall be IDLE and busy shall be 0, independent of clock.
REQ-027 Deasserting reset_n mid-DECAY or mid-count shall restart the block from that reset state; no partial decay shall resume.

Configuration
REQ-028 With LEVEL_METER_HOLD_EN defined, each channel shall add a 3-bit hold counter.
REQ-029 With LEVEL_METER_HOLD_EN defined, a sample that raises a channel's peak shall reload its hold counter to 7.
REQ-030 With LEVEL_METER_HOLD_EN defined, DECAY processing a channel with hold>0 shall decrement hold and leave peak unchanged; with hold=0 it shall decay the peak per REQ-019.
REQ-031 Without LEVEL_METER_HOLD_EN, the block shall have no hold counters and DECAY shall always apply REQ-019.

Structure
REQ-032 A shared package level_meter_pkg shall hold SMP_W=8, PEAK_W=7, LVL_W=4, HOLD_MAX=7 and the FSM state enum {IDLE, DECAY}.
REQ-033 One sub-module, abs_sat, shall implement the combinational saturating magnitude (8-bit signed in, 7-bit out) and be instantiated once.

Verification
REQ-034 Reset check: drive reset_n low mid-operation -> s1..s4=0, busy=0 and all peaks=0 immediately, with no clock edge needed.
REQ-035 Magnitude and latching: samples ch0=-128, ch1=+64, ch2=-8, ch3=0, then one hline -> s1=15, s2=8, s3=1, s4=0.
REQ-036 Decay timing: DECAY_LINES=4, peak0=16, no further samples, hold disabled -> busy high for 4 cycles after every 4th hline; peak0=15 after the first tick and reaches 0 after 16 ticks, then stays 0.
REQ-037 Decay/sample collision: peak2=40, sample ch2=+39 in the same cycle DECAY processes ch2 -> peak2=39; the same with a sample of +20 -> peak2=39.
REQ-038 Hold feature: LEVEL_METER_HOLD_EN defined, sample ch1=+100, DECAY_LINES=1 -> peak1 stays 100 for 7 ticks and reads 99 after the 8th; the same bench without the macro -> 99 after the 1st tick.
REQ-039 Enable gating: ena held low while samples and hline are driven for 100 cycles -> no register changes and busy stays 0.
